// File: rtl/rtc_bus_sequencer_if.sv
// Request and RTC bus signals between a requester and rtc_bus_sequencer.
// The master side issues requests and supplies bus_in; the slave side is the sequencer.
interface rtc_bus_sequencer_if;
  logic       start;
  logic       wr;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic [7:0] bus_in;
  logic       busy;
  logic       done;
  logic [7:0] rdata;
  logic [7:0] mux_a;
  logic [7:0] mux_b;
  logic       sel;
  logic       bus_oe;
  logic       cs_n;
  logic       ale;
  logic       rd_n;
  logic       wr_n;

  modport master (
    output start, wr, addr, wdata, bus_in,
    input  busy, done, rdata, mux_a, mux_b, sel, bus_oe, cs_n, ale, rd_n, wr_n
  );

  modport slave (
    input  start, wr, addr, wdata, bus_in,
    output busy, done, rdata, mux_a, mux_b, sel, bus_oe, cs_n, ale, rd_n, wr_n
  );
endinterface

// File: rtl/rtc_bus_sequencer.sv
// Bus-cycle sequencer for the RTC multiplexed address/data bus: one read or write at a time,
// generating strobes, bus output-enable and the select/operands of the downstream AD mux.
module rtc_bus_sequencer #(
  parameter int unsigned PHASE_CYCLES = 4
) (
  input logic               clk,
  input logic               reset_n,
  rtc_bus_sequencer_if.slave bus
);

  localparam int unsigned    CntW    = $clog2(PHASE_CYCLES) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(PHASE_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StAddr, StTurn, StData, StHold} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            wr_q;
  logic            phase_end;
  logic            accept;
  logic            capture;

  logic       busy_d, done_d, sel_d, bus_oe_d, cs_n_d, ale_d, rd_n_d, wr_n_d;
  logic       busy_q, done_q, sel_q, bus_oe_q, cs_n_q, ale_q, rd_n_q, wr_n_q;
  logic [7:0] rdata_q, mux_a_q, mux_b_q;

  assign phase_end = (cnt_q == CntLast);

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    capture = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StAddr;
          accept  = 1'b1;
        end
      end
      StAddr: if (phase_end) state_d = StTurn;
      StTurn: state_d = StData;
      StData: begin
        if (phase_end) begin
          state_d = StHold;
          capture = ~wr_q;
        end
      end
      StHold:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Counter restarts on every state entry and idles at zero.
    if (state_d == StIdle || state_d != state_q) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    // Outputs are registered, so they are decoded from the state being entered.
    busy_d   = 1'b0;
    sel_d    = 1'b0;
    bus_oe_d = 1'b0;
    cs_n_d   = 1'b1;
    ale_d    = 1'b0;
    rd_n_d   = 1'b1;
    wr_n_d   = 1'b1;
    unique case (state_d)
      StIdle: ;
      StAddr: begin
        busy_d   = 1'b1;
        cs_n_d   = 1'b0;
        ale_d    = 1'b1;
        bus_oe_d = 1'b1;
      end
      StTurn, StHold: begin
        busy_d   = 1'b1;
        cs_n_d   = 1'b0;
        sel_d    = 1'b1;
        bus_oe_d = wr_q;
      end
      StData: begin
        busy_d   = 1'b1;
        cs_n_d   = 1'b0;
        sel_d    = 1'b1;
        bus_oe_d = wr_q;
        wr_n_d   = ~wr_q;
        rd_n_d   = wr_q;
      end
      default: ;
    endcase
    done_d = (state_q == StHold);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      wr_q     <= 1'b0;
      mux_a_q  <= '0;
      mux_b_q  <= '0;
      rdata_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sel_q    <= 1'b0;
      bus_oe_q <= 1'b0;
      cs_n_q   <= 1'b1;
      ale_q    <= 1'b0;
      rd_n_q   <= 1'b1;
      wr_n_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      if (accept) begin
        wr_q    <= bus.wr;
        mux_a_q <= bus.addr;
        mux_b_q <= bus.wdata;
      end
      if (capture) begin
        rdata_q <= bus.bus_in;
      end
      busy_q   <= busy_d;
      done_q   <= done_d;
      sel_q    <= sel_d;
      bus_oe_q <= bus_oe_d;
      cs_n_q   <= cs_n_d;
      ale_q    <= ale_d;
      rd_n_q   <= rd_n_d;
      wr_n_q   <= wr_n_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.rdata  = rdata_q;
  assign bus.mux_a  = mux_a_q;
  assign bus.mux_b  = mux_b_q;
  assign bus.sel    = sel_q;
  assign bus.bus_oe = bus_oe_q;
  assign bus.cs_n   = cs_n_q;
  assign bus.ale    = ale_q;
  assign bus.rd_n   = rd_n_q;
  assign bus.wr_n   = wr_n_q;

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Bench for rtc_bus_sequencer: three instances (P=4, 2, 16) share one stimulus stream and are
// each checked every cycle against a cycle-offset model, plus literal spot checks.
module tb_rtc_bus_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic       wr;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic [7:0] bus_in;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_inst
    localparam int P = (g == 0) ? 4 : ((g == 1) ? 2 : 16);

    rtc_bus_sequencer_if sbus ();
    logic [7:0] mux_out;

    // Model: k is the cycle offset from the accept cycle (cycle 0); -1 when idle.
    int         k    = -1;
    logic [7:0] m_a  = '0;
    logic [7:0] m_b  = '0;
    logic [7:0] m_rd = '0;
    logic       m_wr = 1'b0;

    assign sbus.start  = start;
    assign sbus.wr     = wr;
    assign sbus.addr   = addr;
    assign sbus.wdata  = wdata;
    assign sbus.bus_in = bus_in;

    rtc_bus_sequencer #(.PHASE_CYCLES(P)) u_dut (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (sbus.slave)
    );

    // Downstream registered address/data mux.
    always @(posedge clk) mux_out <= sbus.sel ? sbus.mux_b : sbus.mux_a;

    always @(negedge clk) begin : model
      bit busy_e, addr_ph, strobe_e, post_addr;
      if (!reset_n) begin
        k    = -1;
        m_a  = '0;
        m_b  = '0;
        m_rd = '0;
        m_wr = 1'b0;
      end
      addr_ph   = (k >= 1 && k <= P);
      busy_e    = (k >= 1 && k <= 2*P + 2);
      post_addr = (k >= P + 1 && k <= 2*P + 2);
      strobe_e  = (k >= P + 2 && k <= 2*P + 1);
      chk($sformatf("P%0d busy", P), sbus.busy, busy_e);
      chk($sformatf("P%0d done", P), sbus.done, (k == 2*P + 3));
      chk($sformatf("P%0d ale", P), sbus.ale, addr_ph);
      chk($sformatf("P%0d cs_n", P), sbus.cs_n, !busy_e);
      chk($sformatf("P%0d sel", P), sbus.sel, post_addr);
      chk($sformatf("P%0d bus_oe", P), sbus.bus_oe, addr_ph || (m_wr && post_addr));
      chk($sformatf("P%0d wr_n", P), sbus.wr_n, !(m_wr && strobe_e));
      chk($sformatf("P%0d rd_n", P), sbus.rd_n, !(!m_wr && strobe_e));
      chk($sformatf("P%0d mux_a", P), sbus.mux_a, m_a);
      chk($sformatf("P%0d mux_b", P), sbus.mux_b, m_b);
      chk($sformatf("P%0d rdata", P), sbus.rdata, m_rd);
      if (reset_n) begin
        if (k >= 2 && k <= P + 1) chk($sformatf("P%0d mux out addr", P), mux_out, m_a);
        if (k >= P + 2 && k <= 2*P + 2) chk($sformatf("P%0d mux out data", P), mux_out, m_b);
        if (k == 2*P + 1 && !m_wr) m_rd = bus_in;
        if (!busy_e && start) begin
          k    = 1;
          m_a  = addr;
          m_b  = wdata;
          m_wr = wr;
        end else if (busy_e) begin
          k++;
        end else begin
          k = -1;
        end
      end
    end
  end

  task automatic scramble();
    wr     = 1'($urandom);
    addr   = 8'($urandom);
    wdata  = 8'($urandom);
    bus_in = 8'($urandom);
  endtask

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    scramble();
    for (int i = 0; i < 4; i++) begin
      step();
      start = 1'($urandom);
      scramble();
    end
    step();
    reset_n = 1'b1;
    start   = 1'b0;
    for (int i = 0; i < 3; i++) step();

    // Write 0x45 to 0x21, start in cycle 0.
    start = 1'b1; wr = 1'b1; addr = 8'h21; wdata = 8'h45;
    for (int c = 0; c <= 36; c++) begin
      @(negedge clk);
      if (c == 1)  chk("P4 ale c1", g_inst[0].sbus.ale, 1);
      if (c == 4)  chk("P4 ale c4", g_inst[0].sbus.ale, 1);
      if (c == 5)  chk("P4 ale c5", g_inst[0].sbus.ale, 0);
      if (c == 5)  chk("P4 sel c5", g_inst[0].sbus.sel, 1);
      if (c == 6)  chk("P4 wr_n c6", g_inst[0].sbus.wr_n, 0);
      if (c == 9)  chk("P4 wr_n c9", g_inst[0].sbus.wr_n, 0);
      if (c == 10) chk("P4 wr_n c10", g_inst[0].sbus.wr_n, 1);
      if (c == 10) chk("P4 bus_oe c10", g_inst[0].sbus.bus_oe, 1);
      if (c == 10) chk("P4 busy c10", g_inst[0].sbus.busy, 1);
      if (c == 11) chk("P4 done c11", g_inst[0].sbus.done, 1);
      if (c == 11) chk("P4 rdata after write", g_inst[0].sbus.rdata, 0);
      if (c == 12) chk("P4 done c12", g_inst[0].sbus.done, 0);
      if (c == 2 || c == 3) chk("P2 mux out addr", g_inst[1].mux_out, 8'h21);
      if (c >= 4 && c <= 6) chk("P2 mux out data", g_inst[1].mux_out, 8'h45);
      if (c == 2 || c == 17) chk("P16 mux out addr", g_inst[2].mux_out, 8'h21);
      if (c == 18 || c == 34) chk("P16 mux out data", g_inst[2].mux_out, 8'h45);
      if (c == 35) chk("P16 done c35", g_inst[2].sbus.done, 1);
      step();
      start = 1'b0;
      scramble();
    end

    // Read from 0x0F with bus_in held at 0x59.
    start = 1'b1; wr = 1'b0; addr = 8'h0F; bus_in = 8'h59;
    for (int c = 0; c <= 36; c++) begin
      @(negedge clk);
      if (c == 5)  chk("P4 rd bus_oe c5", g_inst[0].sbus.bus_oe, 0);
      if (c == 6)  chk("P4 rd_n c6", g_inst[0].sbus.rd_n, 0);
      if (c == 9)  chk("P4 rd_n c9", g_inst[0].sbus.rd_n, 0);
      if (c == 9)  chk("P4 rdata c9", g_inst[0].sbus.rdata, 0);
      if (c == 10) chk("P4 rd bus_oe c10", g_inst[0].sbus.bus_oe, 0);
      if (c == 10) chk("P4 rdata c10", g_inst[0].sbus.rdata, 8'h59);
      if (c == 11) chk("P4 rd done c11", g_inst[0].sbus.done, 1);
      step();
      start = 1'b0;
      wr    = 1'($urandom);
      addr  = 8'($urandom);
    end

    // Ignored starts in cycles 3 and 8, accepted start in the done cycle.
    start = 1'b1; wr = 1'b1; addr = 8'h33; wdata = 8'h77;
    for (int c = 0; c <= 50; c++) begin
      @(negedge clk);
      if (c == 10) chk("P4 mux_a held", g_inst[0].sbus.mux_a, 8'h33);
      if (c == 11) chk("P4 done before b2b", g_inst[0].sbus.done, 1);
      if (c == 12) chk("P4 b2b ale", g_inst[0].sbus.ale, 1);
      if (c == 12) chk("P4 b2b busy", g_inst[0].sbus.busy, 1);
      if (c == 13) chk("P4 b2b mux_a", g_inst[0].sbus.mux_a, 8'h5A);
      step();
      scramble();
      start = (c + 1 == 3) || (c + 1 == 8) || (c + 1 == 11);
      if (c + 1 == 11) addr = 8'h5A;
    end

    // Reset abort in cycle 7 of a write.
    start = 1'b1; wr = 1'b1; addr = 8'h21; wdata = 8'h45;
    for (int c = 0; c <= 20; c++) begin
      @(negedge clk);
      if (c == 7)  chk("P4 abort wr_n", g_inst[0].sbus.wr_n, 1);
      if (c == 7)  chk("P4 abort cs_n", g_inst[0].sbus.cs_n, 1);
      if (c == 7)  chk("P4 abort ale", g_inst[0].sbus.ale, 0);
      if (c == 7)  chk("P4 abort busy", g_inst[0].sbus.busy, 0);
      if (c == 11) chk("P4 abort no done", g_inst[0].sbus.done, 0);
      step();
      start = 1'b0;
      scramble();
      if (c + 1 == 7) reset_n = 1'b0;
      if (c + 1 == 9) reset_n = 1'b1;
    end
    start = 1'b1; wr = 1'b1; addr = 8'h21; wdata = 8'h45;
    for (int c = 0; c <= 40; c++) begin
      @(negedge clk);
      if (c == 10) chk("P4 fresh mux_b", g_inst[0].sbus.mux_b, 8'h45);
      if (c == 11) chk("P4 fresh done", g_inst[0].sbus.done, 1);
      step();
      start = 1'b0;
      scramble();
    end

    // Random traffic with occasional single-cycle resets.
    for (int i = 0; i < 3000; i++) begin
      step();
      start   = ($urandom_range(0, 3) == 0);
      reset_n = ($urandom_range(0, 299) != 0);
      scramble();
    end
    step();
    reset_n = 1'b1;
    start   = 1'b0;
    for (int i = 0; i < 40; i++) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rtc_bus_sequencer.md
# rtc_bus_sequencer

Bus-cycle sequencer for the external RTC multiplexed address/data bus. It accepts one read or write request at a time and generates the chip strobes (cs_n, ale, rd_n, wr_n) and the bus output-enable. It also drives the operands and select of the downstream 8-bit registered address/data mux (0 = address on A, 1 = data on B). Read data sampled from the bus is returned on rdata, and every transaction ends with a one-cycle done pulse.

## Interface
Parameters:
- PHASE_CYCLES, 4, length in clk cycles of the address phase and of the data-strobe phase; legal range 2..16.

Ports:
- clk  in  1  system clock; all state changes on rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only while idle (busy=0)
- wr  in  1  1 = write, 0 = read; sampled with start
- addr  in  8  register address; sampled with start
- wdata  in  8  write data; sampled with start
- bus_in  in  8  value read back from the AD bus
- busy  out  1  transaction in progress
- done  out  1  one-cycle pulse at transaction end
- rdata  out  8  last read result
- mux_a  out  8  latched address, feeds mux input A
- mux_b  out  8  latched wdata, feeds mux input B
- sel  out  1  mux select: 0 = address, 1 = data
- bus_oe  out  1  1 = FPGA drives AD bus
- cs_n, ale, rd_n, wr_n  out  1 each  RTC chip select, address-latch enable, read strobe, write strobe

## Operation
- All outputs are registered.
- Reset values: busy=0, done=0, rdata=0, mux_a=0, mux_b=0, sel=0, bus_oe=0, cs_n=1, ale=0, rd_n=1, wr_n=1. State is IDLE and the phase counter is 0.
- Counter width is $clog2(PHASE_CYCLES)+1. The counter restarts at 0 on every state entry.
- IDLE
  - Outputs: busy=0, sel=0, bus_oe=0, cs_n=1, ale=0, rd_n=1, wr_n=1.
  - On start=1: latch addr into mux_a, latch wdata into mux_b, latch wr, then go to ADDR.
- ADDR (PHASE_CYCLES cycles)
  - Outputs: cs_n=0, ale=1, bus_oe=1, sel=0.
  - Goes to TURN.
- TURN (1 cycle)
  - Outputs: ale=0, cs_n=0, sel=1, bus_oe=wr.
  - The downstream mux registers its input, so sel switches one cycle before the strobe.
- DATA (PHASE_CYCLES cycles)
  - Write: wr_n=0, bus_oe=1. Read: rd_n=0, bus_oe=0.
  - On a read, rdata<=bus_in at the edge ending the last DATA cycle.
  - Goes to HOLD.
- HOLD (1 cycle)
  - Outputs: rd_n=1, wr_n=1, cs_n=0, sel=1, bus_oe=wr (write data held past the wr_n rising edge).
  - Goes to IDLE with done=1.
- done is high only in the first IDLE cycle after HOLD.
- rdata is unchanged by writes and holds its value until the next read completes.
- start while busy=1 is ignored; there is no queueing.
- start in the done cycle is accepted, giving back-to-back transactions.
- Reset asserted mid-transaction immediately forces the reset values. No done pulse is produced, and the aborted request is lost.
- Values of addr, wdata and wr after the accept edge have no effect on the transaction in progress.

## Timing
- Cycle 0 is the cycle in which start=1 is sampled in IDLE. With P=PHASE_CYCLES:
  - ADDR: cycles 1..P
  - TURN: cycle P+1
  - DATA: cycles P+2..2P+1
  - HOLD: cycle 2P+2
  - done: cycle 2P+3
- busy is high in cycles 1..2P+2, i.e. 2P+2 cycles per transaction.
- Mux output (one-cycle registered):
  - Address valid cycles 2..P+1, i.e. stable before and through the ale falling edge.
  - Data valid cycles P+2..2P+2, i.e. covering the whole strobe plus hold.
- Read latency: rdata is valid in cycle 2P+2 and stays valid thereafter.
- Minimum start-to-start spacing: 2P+3 cycles.

## Test plan
- Reset: hold reset_n=0 with random inputs -> all outputs at reset values. Release -> IDLE, and nothing happens until start.
- Write, P=4, addr=0x21, wdata=0x45, start in cycle 0:
  - ale=1 in cycles 1-4
  - wr_n=0 in cycles 6-9
  - sel=1 in cycles 5-10
  - bus_oe=1 in cycles 1-10
  - busy=1 in cycles 1-10
  - done=1 in cycle 11 only
  - rdata unchanged
- Read, P=4, addr=0x0F, bus_in=0x59 during DATA:
  - rd_n=0 in cycles 6-9
  - bus_oe=0 in cycles 5-10
  - rdata=0x59 from cycle 10
  - done in cycle 11
- Request rules:
  - start pulses in cycles 3 and 8 of a transaction are ignored.
  - start in the done cycle is accepted: the next ale rises the following cycle.
  - Changing addr in cycle 2 does not alter mux_a.
- Reset abort: drop reset_n in cycle 7 of a write -> wr_n, cs_n and ale inactive and busy=0 immediately; no done; a fresh write after release completes normally.
- With the registered address/data mux attached, P=2: mux output=0x21 in cycles 2-3 and 0x45 in cycles 4-6; repeat with P=16 and check the same cycle formulas.
